// File: rtl/mmm_nlp_modexp.sv
// Modular exponentiation M^E mod N using left-to-right square-and-multiply
// over a radix-2 bit-serial Montgomery product (R = 2^DW).
module mmm_nlp_modexp #(
   parameter int DW = 256,
   parameter int EW = 256
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_m,
   input  logic [EW-1:0] i_e,
   input  logic [DW-1:0] i_n,
   input  logic [DW-1:0] i_r2,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_res,
   output logic          o_err
);

   localparam int CW = $clog2(DW + 1);
   localparam int IW = (EW > 1) ? $clog2(EW) : 1;
   localparam logic [DW-1:0] ONE = DW'(1);

   typedef enum logic [2:0] {
      IDLE,
      PRE_M,
      PRE_A,
      SQR,
      MUL,
      POST,
      DONE
   } state_t;

   state_t        r_state;
   logic          r_ready;
   logic          r_valid;
   logic          r_err;
   logic [DW-1:0] r_res;
   logic [EW-1:0] r_e;
   logic [DW-1:0] r_n;
   logic [DW-1:0] r_r2;
   logic [DW-1:0] r_mbar;
   logic [DW-1:0] r_x;
   logic [DW-1:0] r_y;
   logic [DW+1:0] r_a;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;

   logic [DW+1:0] w_sum1;
   logic [DW+1:0] w_sum2;
   logic [DW+1:0] w_step;
   logic [DW+1:0] w_sub;
   logic [DW-1:0] w_res;
   logic          w_last;

   // Accumulator stays below 2^(DW+1), so A + Y + N fits in DW+2 bits.
   always_comb begin
      w_sum1 = r_a + (r_x[0] ? {2'b00, r_y} : '0);
      w_sum2 = w_sum1 + (w_sum1[0] ? {2'b00, r_n} : '0);
      w_step = w_sum2 >> 1;
      w_sub  = r_a - {2'b00, r_n};
      w_res  = (r_a >= {2'b00, r_n}) ? w_sub[DW-1:0] : r_a[DW-1:0];
      w_last = (r_cnt == CW'(DW));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_res   <= '0;
         r_e     <= '0;
         r_n     <= '0;
         r_r2    <= '0;
         r_mbar  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_a     <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         // Bit-serial step shared by every computing state; the final count
         // performs the conditional subtract and hands off to the next product.
         if (r_state != IDLE && r_state != DONE) begin
            if (!w_last) begin
               r_a   <= w_step;
               r_x   <= r_x >> 1;
               r_cnt <= r_cnt + CW'(1);
            end else begin
               r_a   <= '0;
               r_cnt <= '0;
            end
         end

         case (r_state)
            IDLE: begin
               if (i_valid) begin
                  r_ready <= 1'b0;
                  r_e     <= i_e;
                  r_n     <= i_n;
                  r_r2    <= i_r2;
                  r_x     <= i_m;
                  r_y     <= i_r2;
                  r_a     <= '0;
                  r_cnt   <= '0;
                  if (!i_n[0]) begin
                     r_state <= DONE;
                     r_valid <= 1'b1;
                     r_err   <= 1'b1;
                     r_res   <= '0;
                  end else begin
                     r_state <= PRE_M;
                  end
               end
            end
            PRE_M: begin
               if (w_last) begin
                  r_mbar  <= w_res;
                  r_x     <= r_r2;
                  r_y     <= ONE;
                  r_state <= PRE_A;
               end
            end
            PRE_A: begin
               if (w_last) begin
                  r_x     <= w_res;
                  r_y     <= w_res;
                  r_idx   <= IW'(EW - 1);
                  r_state <= SQR;
               end
            end
            SQR: begin
               if (w_last) begin
                  r_x <= w_res;
                  if (r_e[r_idx]) begin
                     r_y     <= r_mbar;
                     r_state <= MUL;
                  end else if (r_idx == '0) begin
                     r_y     <= ONE;
                     r_state <= POST;
                  end else begin
                     r_y     <= w_res;
                     r_idx   <= r_idx - IW'(1);
                     r_state <= SQR;
                  end
               end
            end
            MUL: begin
               if (w_last) begin
                  r_x <= w_res;
                  if (r_idx == '0) begin
                     r_y     <= ONE;
                     r_state <= POST;
                  end else begin
                     r_y     <= w_res;
                     r_idx   <= r_idx - IW'(1);
                     r_state <= SQR;
                  end
               end
            end
            POST: begin
               if (w_last) begin
                  r_res   <= w_res;
                  r_valid <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
                  r_res   <= '0;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
               r_res   <= '0;
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_res   = r_res;
   assign o_err   = r_err;

endmodule

// File: tb/tb_mmm_nlp_modexp.sv
// Scoreboard bench for mmm_nlp_modexp at DW=8, EW=8: the driver queues the
// expected result and latency, a negedge monitor checks whatever the DUT presents.
module tb_mmm_nlp_modexp;

   localparam int DW = 8;
   localparam int EW = 8;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] i_m;
   logic [EW-1:0] i_e;
   logic [DW-1:0] i_n;
   logic [DW-1:0] i_r2;
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_res;
   logic          o_err;

   typedef struct {
      logic [DW-1:0] res;
      logic          err;
      int            lat;
      int            acc;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   last_hs = -100;
   bit   seen    = 1'b0;

   mmm_nlp_modexp #(.DW(DW), .EW(EW)) u_dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_m     (i_m),
      .i_e     (i_e),
      .i_n     (i_n),
      .i_r2    (i_r2),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on first sighting, payload every valid cycle, pop on handshake.
   always begin
      @(negedge i_clk);
      #1;
      if (!i_rst) begin
         if (o_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got o_res=%0d expected no result", o_res);
            end else begin
               if (!seen) begin
                  chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                  seen = 1'b1;
               end
               chk("o_res", o_res, sb[0].res);
               chk("o_err", o_err, sb[0].err);
               chk("o_ready_busy", o_ready, 0);
               if (i_ready) begin
                  void'(sb.pop_front());
                  last_hs = cyc + 1;
                  seen    = 1'b0;
               end
            end
         end else begin
            seen = 1'b0;
            chk("o_res_idle", o_res, 0);
         end
      end
   end

   task automatic issue(input logic [DW-1:0] m, input logic [EW-1:0] e,
                        input logic [DW-1:0] n, input logic [DW-1:0] r2,
                        input logic [DW-1:0] res, input logic err, input int lat,
                        input bit hold, input bit b2b);
      exp_t x;
      bit   got;
      @(negedge i_clk);
      i_m     = m;
      i_e     = e;
      i_n     = n;
      i_r2    = r2;
      i_valid = 1'b1;
      got     = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (o_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got o_ready=0 expected 1 within 1000 cycles");
         i_valid = 1'b0;
         return;
      end
      x.res = res;
      x.err = err;
      x.lat = lat;
      x.acc = cyc + 1;
      sb.push_back(x);
      if (b2b) chk("b2b_accept_cycle", x.acc, last_hs + 1);
      if (!hold) begin
         @(negedge i_clk);
         i_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget);
      checks++;
      for (int k = 0; k < budget; k++) begin
         @(negedge i_clk);
         if (sb.size() == 0 && o_ready) return;
      end
      errors++;
      $display("FAIL done_timeout: got pending=%0d expected 0 within %0d cycles", sb.size(), budget);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Request presented during reset must be dropped.
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_m     = 8'd5;
      i_e     = 8'd3;
      i_n     = 8'd187;
      i_r2    = 8'd86;
      repeat (3) @(negedge i_clk);
      i_rst   = 1'b0;
      i_valid = 1'b0;
      chk("reset_o_ready", o_ready, 1);
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_res",   o_res,   0);
      chk("reset_o_err",   o_err,   0);

      issue(8'd5,   8'd3,  8'd187, 8'd86, 8'd125, 1'b0, 118, 1'b0, 1'b0);
      wait_idle(400);
      issue(8'd186, 8'd2,  8'd187, 8'd86, 8'd1,   1'b0, 109, 1'b0, 1'b0);
      wait_idle(400);
      issue(8'd186, 8'd0,  8'd187, 8'd86, 8'd1,   1'b0, 100, 1'b0, 1'b0);
      wait_idle(400);
      issue(8'd5,   8'd3,  8'd100, 8'd0,  8'd0,   1'b1, 1,   1'b0, 1'b0);
      wait_idle(400);
      issue(8'd0,   8'd5,  8'd1,   8'd0,  8'd0,   1'b0, 118, 1'b0, 1'b0);
      wait_idle(400);
      issue(8'd2,   8'd10, 8'd187, 8'd86, 8'd89,  1'b0, 118, 1'b0, 1'b0);
      wait_idle(400);
      issue(8'd3,   8'd7,  8'd255, 8'd1,  8'd147, 1'b0, 127, 1'b0, 1'b0);
      wait_idle(400);

      // Backpressure: result held for 20 cycles while a new request is offered.
      i_ready = 1'b0;
      issue(8'd5, 8'd3, 8'd187, 8'd86, 8'd125, 1'b0, 118, 1'b0, 1'b0);
      begin
         bit vis;
         vis = 1'b0;
         for (int k = 0; k < 400; k++) begin
            if (o_valid) begin
               vis = 1'b1;
               break;
            end
            @(negedge i_clk);
         end
         chk("bp_valid_seen", vis, 1);
      end
      repeat (20) begin
         @(negedge i_clk);
         i_valid = 1'b1;
         i_m     = 8'd7;
         i_e     = 8'd1;
         i_n     = 8'd187;
         chk("bp_o_ready_stall", o_ready, 0);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("bp_idle_o_ready", o_ready, 1);
      chk("bp_idle_o_valid", o_valid, 0);
      wait_idle(10);

      // Reset during computation: nothing emitted, re-issue behaves normally.
      issue(8'd5, 8'd3, 8'd187, 8'd86, 8'd125, 1'b0, 118, 1'b0, 1'b0);
      repeat (49) @(negedge i_clk);
      i_rst = 1'b1;
      sb.delete();
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("abort_o_ready", o_ready, 1);
      chk("abort_o_valid", o_valid, 0);
      chk("abort_o_res",   o_res,   0);
      issue(8'd5, 8'd3, 8'd187, 8'd86, 8'd125, 1'b0, 118, 1'b0, 1'b0);
      wait_idle(400);

      // Back-to-back with i_valid held high across the first result.
      issue(8'd5, 8'd255, 8'd187, 8'd86, 8'd177, 1'b0, 172, 1'b1, 1'b0);
      issue(8'd5, 8'd3,   8'd187, 8'd86, 8'd125, 1'b0, 118, 1'b0, 1'b1);
      wait_idle(400);

      repeat (2) @(negedge i_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
